// File: rtl/dx_pipeline_stage_pkg.sv
// Shared constants for the decode-to-execute stage: bubble encodings and
// bit positions inside the 8-bit control bundle.
package dx_pipeline_stage_pkg;

  localparam logic [2:0] ALU_OP_NOOP = 3'h1;

  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_ALU_SRC   = 6;
  localparam int CTRL_REG_DST   = 5;
  localparam int CTRL_MEM_REG   = 4;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_JUMP      = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_READ  = 0;

  localparam logic [7:0] CTRL_BUBBLE = 8'h00;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/dx_bundle_reg.sv
// Enabled register for one pipeline bundle. A bubble load overwrites only
// the control part with the bubble encoding and leaves the data part alone.
module dx_bundle_reg #(
  parameter int                DATA_W       = 32,
  parameter int                CTRL_W       = 11,
  parameter logic [CTRL_W-1:0] BUBBLE_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= BUBBLE_VALUE;
    end else if (load) begin
      ctrl_q <= bubble ? BUBBLE_VALUE : ctrl_d;
      if (!bubble) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/dx_pipeline_stage.sv
// Decode-to-execute pipeline register with a one-entry skid buffer, flush
// support and a saturating count of downstream stall cycles.
module dx_pipeline_stage
  import dx_pipeline_stage_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         REG_ADDR_WIDTH = 5,
  parameter logic [2:0] NOOP_ALU_OP    = ALU_OP_NOOP
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       pc_value_next,
  input  logic [DATA_WIDTH-1:0]       read_data_0,
  input  logic [DATA_WIDTH-1:0]       read_data_1,
  input  logic [DATA_WIDTH-1:0]       immediate,
  input  logic [2:0]                  alu_op,
  input  logic [7:0]                  ctrl,
  input  logic [3*REG_ADDR_WIDTH-1:0] reg_addrs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       pc_value,
  output logic [DATA_WIDTH-1:0]       read_data_buffered_0,
  output logic [DATA_WIDTH-1:0]       read_data_buffered_1,
  output logic [DATA_WIDTH-1:0]       immediate_buffered,
  output logic [2:0]                  alu_op_buffered,
  output logic [7:0]                  ctrl_buffered,
  output logic [3*REG_ADDR_WIDTH-1:0] reg_addrs_buffered,
  output logic [15:0]                 stall_cycles
);

  localparam int              BUNDLE_W = 4*DATA_WIDTH + 3*REG_ADDR_WIDTH;
  localparam int              CTRL_W   = 11;
  localparam logic [CTRL_W-1:0] BUBBLE = {NOOP_ALU_OP, CTRL_BUBBLE};

  logic                skid_valid;
  logic                accept;
  logic                m_advance;
  logic                m_load;
  logic                m_bubble;
  logic                s_load;
  logic [BUNDLE_W-1:0] in_data;
  logic [BUNDLE_W-1:0] m_data;
  logic [BUNDLE_W-1:0] m_data_d;
  logic [BUNDLE_W-1:0] s_data;
  logic [CTRL_W-1:0]   in_ctrl;
  logic [CTRL_W-1:0]   m_ctrl;
  logic [CTRL_W-1:0]   m_ctrl_d;
  logic [CTRL_W-1:0]   s_ctrl;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready & ~flush;
  assign m_advance = ~out_valid | out_ready;
  assign s_load    = ~flush & out_valid & ~out_ready & accept;

  assign m_load    = flush | m_advance;
  assign m_bubble  = flush | ~(skid_valid | accept);
  assign in_data   = {pc_value_next, read_data_0, read_data_1, immediate, reg_addrs};
  assign in_ctrl   = {alu_op, ctrl};
  assign m_data_d  = skid_valid ? s_data : in_data;
  assign m_ctrl_d  = skid_valid ? s_ctrl : in_ctrl;

  dx_bundle_reg #(
    .DATA_W       (BUNDLE_W),
    .CTRL_W       (CTRL_W),
    .BUBBLE_VALUE (BUBBLE)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (m_load),
    .bubble (m_bubble),
    .data_d (m_data_d),
    .ctrl_d (m_ctrl_d),
    .data_q (m_data),
    .ctrl_q (m_ctrl)
  );

  dx_bundle_reg #(
    .DATA_W       (BUNDLE_W),
    .CTRL_W       (CTRL_W),
    .BUBBLE_VALUE (BUBBLE)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (s_load),
    .bubble (1'b0),
    .data_d (in_data),
    .ctrl_d (in_ctrl),
    .data_q (s_data),
    .ctrl_q (s_ctrl)
  );

  assign {pc_value, read_data_buffered_0, read_data_buffered_1,
          immediate_buffered, reg_addrs_buffered} = m_data;
  assign {alu_op_buffered, ctrl_buffered} = m_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (m_advance) begin
        out_valid  <= skid_valid | accept;
        skid_valid <= 1'b0;
      end else if (s_load) begin
        skid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && stall_cycles != STALL_MAX) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
